// File: rtl/branch_unit_bht.sv
// ---------------------------------------------------------------------------
// branch_unit_bht
//
// Resolves MIPS conditional branches from ALU flags (six condition modes) and
// keeps a branch history table of saturating counters. The table predicts
// taken/not-taken for the fetch PC and is trained by every valid resolved
// branch. Mispredicts are flagged so hazard logic can flush the pipe.
//
// Optional feature macro: BRANCH_STATS_EN
//   When defined, adds saturating counters for resolved branches and
//   mispredicts (branch_count, mispredict_count).
//
// Ports:
//   clk              in   rising-edge clock
//   reset_n          in   asynchronous active-low reset
//   fetch_pc         in   PC of the instruction being fetched
//   predict_taken    out  prediction for fetch_pc (combinational table read)
//   branch_en        in   execute-stage instruction is a conditional branch
//   cond             in   condition mode (11x reserved -> branch not valid)
//   alu_zero         in   ALU result equals zero
//   alu_neg          in   ALU result sign bit
//   resolve_pc       in   PC of the branch being resolved
//   resolve_pred     in   prediction that travelled with the branch
//   branch           out  branch is taken (combinational)
//   mispredict       out  outcome differs from resolve_pred (combinational)
//   branch_count     out  valid resolved branches   (BRANCH_STATS_EN only)
//   mispredict_count out  mispredicted branches     (BRANCH_STATS_EN only)
// ---------------------------------------------------------------------------
module branch_unit_bht #(
  parameter int BHT_DEPTH  = 64,
  parameter int CTR_WIDTH  = 2,
  parameter int PC_WIDTH   = 32,
  parameter int STAT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [PC_WIDTH-1:0]   fetch_pc,
  output logic                  predict_taken,
  input  logic                  branch_en,
  input  logic [2:0]            cond,
  input  logic                  alu_zero,
  input  logic                  alu_neg,
  input  logic [PC_WIDTH-1:0]   resolve_pc,
  input  logic                  resolve_pred,
  output logic                  branch,
  output logic                  mispredict
`ifdef BRANCH_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0] branch_count,
  output logic [STAT_WIDTH-1:0] mispredict_count
`endif
);

  localparam int IW = $clog2(BHT_DEPTH);

  // Weakly-not-taken reset value: 2^(CTR_WIDTH-1) - 1 (0 for 1-bit counters).
  localparam logic [CTR_WIDTH-1:0] CTR_WNT = CTR_WIDTH'((2 ** (CTR_WIDTH - 1)) - 1);
  localparam logic [CTR_WIDTH-1:0] CTR_MAX = '1;
  localparam logic [CTR_WIDTH-1:0] CTR_ONE = CTR_WIDTH'(1);

  typedef enum logic [2:0] {
    COND_EQ  = 3'b000,
    COND_NE  = 3'b001,
    COND_LEZ = 3'b010,
    COND_GTZ = 3'b011,
    COND_LTZ = 3'b100,
    COND_GEZ = 3'b101
  } cond_e;

  logic                 cond_true;
  logic                 cond_ok;
  logic                 valid;
  logic [IW-1:0]        fetch_idx;
  logic [IW-1:0]        resolve_idx;
  logic [CTR_WIDTH-1:0] ctr_cur;
  logic [CTR_WIDTH-1:0] ctr_d;
  logic [CTR_WIDTH-1:0] bht_q [BHT_DEPTH];

  // Word-aligned PCs: bits [1:0] never select an entry, upper bits alias.
  assign fetch_idx   = fetch_pc[IW+1:2];
  assign resolve_idx = resolve_pc[IW+1:2];

  logic unused_pc_bits;
  assign unused_pc_bits = ^{fetch_pc, resolve_pc};

  // ---------------------------------------------------------------------------
  // Branch resolution
  // ---------------------------------------------------------------------------
  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    cond_true = 1'b0;
    cond_ok   = 1'b1;
    case (cond_e'(cond))
      COND_EQ:  cond_true = alu_zero;
      COND_NE:  cond_true = ~alu_zero;
      COND_LEZ: cond_true = alu_neg | alu_zero;
      COND_GTZ: cond_true = ~alu_neg & ~alu_zero;
      COND_LTZ: cond_true = alu_neg;
      COND_GEZ: cond_true = ~alu_neg;
      default:  cond_ok   = 1'b0;
    endcase
  end

  assign valid      = branch_en & cond_ok;
  assign branch     = valid & cond_true;
  assign mispredict = valid & (branch ^ resolve_pred);

  // ---------------------------------------------------------------------------
  // Branch history table
  // ---------------------------------------------------------------------------
  // Read is combinational with no write bypass: a same-cycle update to the
  // fetched entry shows up only after the edge.
  assign predict_taken = bht_q[fetch_idx][CTR_WIDTH-1];

  assign ctr_cur = bht_q[resolve_idx];

  always_comb begin
    ctr_d = ctr_cur;
    if (branch) begin
      if (ctr_cur != CTR_MAX) ctr_d = ctr_cur + CTR_ONE;
    end else begin
      if (ctr_cur != '0) ctr_d = ctr_cur - CTR_ONE;
    end
  end

  // NOTE: the table is built from flops rather than a RAM macro because every
  // entry must return to weakly-not-taken asynchronously on reset; a RAM
  // could only be cleared by a multi-cycle sweep.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht_q[i] <= CTR_WNT;
      end
    end else if (valid) begin
      bht_q[resolve_idx] <= ctr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional statistics
  // ---------------------------------------------------------------------------
`ifdef BRANCH_STATS_EN
  localparam logic [STAT_WIDTH-1:0] STAT_ONE = STAT_WIDTH'(1);

  logic [STAT_WIDTH-1:0] branch_count_q;
  logic [STAT_WIDTH-1:0] mispredict_count_q;

  // Both counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      if (valid && (branch_count_q != '1)) begin
        branch_count_q <= branch_count_q + STAT_ONE;
      end
      if (mispredict && (mispredict_count_q != '1)) begin
        mispredict_count_q <= mispredict_count_q + STAT_ONE;
      end
    end
  end

  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;
`else
  logic [STAT_WIDTH-1:0] unused_stat_width;
  assign unused_stat_width = '0;
`endif

endmodule

// File: tb/tb_branch_unit_bht.sv
// ---------------------------------------------------------------------------
// tb_branch_unit_bht
//
// Self-checking bench for branch_unit_bht. A behavioural model keeps each
// table entry as a plain integer clamped to [0, 2^CTR_WIDTH-1]; a prediction
// is "taken" when the integer reaches the upper half of that range.
// Inputs are driven on the falling edge, outputs are sampled 1 ns later.
// Define BRANCH_STATS_EN to also exercise the statistics counters.
// ---------------------------------------------------------------------------
module tb_branch_unit_bht;

  localparam int BHT_DEPTH = 64;
  localparam int CTR_WIDTH = 2;
  localparam int PC_WIDTH  = 32;
`ifdef BRANCH_STATS_EN
  localparam int STAT_WIDTH = 4;
`else
  localparam int STAT_WIDTH = 32;
`endif
  localparam int CTR_MAX  = (2 ** CTR_WIDTH) - 1;
  localparam int CTR_INIT = (2 ** (CTR_WIDTH - 1)) - 1;

  logic                clk;
  logic                reset_n;
  logic [PC_WIDTH-1:0] fetch_pc;
  logic                predict_taken;
  logic                branch_en;
  logic [2:0]          cond;
  logic                alu_zero;
  logic                alu_neg;
  logic [PC_WIDTH-1:0] resolve_pc;
  logic                resolve_pred;
  logic                branch;
  logic                mispredict;
`ifdef BRANCH_STATS_EN
  logic [STAT_WIDTH-1:0] branch_count;
  logic [STAT_WIDTH-1:0] mispredict_count;
`endif

  branch_unit_bht #(
    .BHT_DEPTH  (BHT_DEPTH),
    .CTR_WIDTH  (CTR_WIDTH),
    .PC_WIDTH   (PC_WIDTH),
    .STAT_WIDTH (STAT_WIDTH)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .fetch_pc         (fetch_pc),
    .predict_taken    (predict_taken),
    .branch_en        (branch_en),
    .cond             (cond),
    .alu_zero         (alu_zero),
    .alu_neg          (alu_neg),
    .resolve_pc       (resolve_pc),
    .resolve_pred     (resolve_pred),
    .branch           (branch),
    .mispredict       (mispredict)
`ifdef BRANCH_STATS_EN
    ,
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------------------------------------------------------------------
  // Reference model and bookkeeping
  // ---------------------------------------------------------------------------
  int model_ctr [BHT_DEPTH];
  int stat_br;
  int stat_mp;
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_cond(input int c, input bit z, input bit n);
    case (c)
      0:       return z;
      1:       return !z;
      2:       return n || z;
      3:       return !n && !z;
      4:       return n;
      5:       return !n;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int idx_of(input logic [PC_WIDTH-1:0] pc);
    return int'((pc / 4) % BHT_DEPTH);
  endfunction

  function automatic bit model_pred(input logic [PC_WIDTH-1:0] pc);
    return model_ctr[idx_of(pc)] > CTR_INIT;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < BHT_DEPTH; i++) model_ctr[i] = CTR_INIT;
    stat_br = 0;
    stat_mp = 0;
  endtask

`ifdef BRANCH_STATS_EN
  function automatic int sat_stat(input int v);
    return (v > (2 ** STAT_WIDTH) - 1) ? (2 ** STAT_WIDTH) - 1 : v;
  endfunction
`endif

  // One resolve cycle: drive on the falling edge, check the combinational
  // outputs against the pre-edge model, then let the rising edge train.
  task automatic do_cycle(input bit en, input int c, input bit z, input bit n,
                          input logic [PC_WIDTH-1:0] rpc, input bit pred,
                          input logic [PC_WIDTH-1:0] fpc, input string tag);
    bit v, b, m;
    int i;
    @(negedge clk);
    branch_en    = en;
    cond         = 3'(c);
    alu_zero     = z;
    alu_neg      = n;
    resolve_pc   = rpc;
    resolve_pred = pred;
    fetch_pc     = fpc;
    #1;
    v = en && (c < 6);
    b = v && model_cond(c, z, n);
    m = v && (b != pred);
    check({tag, ".branch"}, branch, b);
    check({tag, ".mispredict"}, mispredict, m);
    check({tag, ".predict"}, predict_taken, model_pred(fpc));
    @(posedge clk);
    if (v) begin
      i = idx_of(rpc);
      if (b) model_ctr[i] = (model_ctr[i] < CTR_MAX) ? model_ctr[i] + 1 : CTR_MAX;
      else   model_ctr[i] = (model_ctr[i] > 0) ? model_ctr[i] - 1 : 0;
      stat_br++;
      if (m) stat_mp++;
    end
  endtask

  task automatic check_fetch(input logic [PC_WIDTH-1:0] fpc, input string tag);
    @(negedge clk);
    branch_en = 1'b0;
    fetch_pc  = fpc;
    #1;
    check(tag, predict_taken, model_pred(fpc));
  endtask

  // ---------------------------------------------------------------------------
  // Directed + randomized sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [PC_WIDTH-1:0] rpc;
    logic [PC_WIDTH-1:0] fpc;

    reset_n      = 1'b0;
    branch_en    = 1'b0;
    cond         = 3'd0;
    alu_zero     = 1'b0;
    alu_neg      = 1'b0;
    resolve_pc   = '0;
    resolve_pred = 1'b0;
    fetch_pc     = '0;
    model_reset();

    // Reset state
    #2;
    check("reset.predict", predict_taken, 1'b0);
`ifdef BRANCH_STATS_EN
    check("reset.branch_count", branch_count, '0);
    check("reset.mispredict_count", mispredict_count, '0);
`endif
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Every entry starts weakly-not-taken
    for (int pc = 0; pc <= 'hFC; pc += 4) begin
      check_fetch(PC_WIDTH'(pc), "sweep.predict");
    end

    // Training at 0x40: 1->2->3->3, prediction flips after the first edge
    for (int k = 0; k < 4; k++) begin
      do_cycle(1'b1, 0, 1'b1, 1'b0, 32'h40, 1'b0, 32'h40, "train");
    end
    check_fetch(32'h40, "train.after");
    // One not-taken from a saturated 3 must stay in the taken half
    do_cycle(1'b1, 0, 1'b0, 1'b0, 32'h40, 1'b1, 32'h40, "train.dec");
    check_fetch(32'h40, "train.dec.after");

    // Condition truth table, reserved codes leave the counter untouched
    for (int c = 0; c < 8; c++) begin
      for (int zn = 0; zn < 4; zn++) begin
        do_cycle(1'b1, c, zn[1], zn[0], PC_WIDTH'(32'h80 + 4 * c), 1'b0,
                 PC_WIDTH'(32'h80 + 4 * c), "truth");
      end
      check_fetch(PC_WIDTH'(32'h80 + 4 * c), "truth.ctr");
    end

    // Aliasing: 0x004 and 0x104 share an entry, 0x008 does not
    do_cycle(1'b1, 0, 1'b1, 1'b0, 32'h004, 1'b0, 32'h0, "alias");
    do_cycle(1'b1, 0, 1'b1, 1'b0, 32'h004, 1'b0, 32'h0, "alias");
    check_fetch(32'h104, "alias.same_idx");
    check(("alias.same_idx.const"), predict_taken, 1'b1);
    check_fetch(32'h008, "alias.other_idx");
    check(("alias.other_idx.const"), predict_taken, 1'b0);

    // Same-cycle read/write of entry 0x20: old value now, new value next cycle
    do_cycle(1'b1, 1, 1'b0, 1'b0, 32'h20, 1'b0, 32'h20, "conflict");
    #1;
    check("conflict.next", predict_taken, 1'b1);

    // Randomized traffic with aliasing upper bits and unaligned low bits
    for (int k = 0; k < 400; k++) begin
      rpc = ($urandom & 32'hFFFF_FF00) | (PC_WIDTH'($urandom_range(0, 15)) << 2)
            | PC_WIDTH'($urandom_range(0, 3));
      fpc = ($urandom_range(0, 1) == 1) ? rpc : PC_WIDTH'($urandom);
      do_cycle($urandom_range(0, 9) < 8, int'($urandom_range(0, 7)),
               1'($urandom), 1'($urandom), rpc, 1'($urandom), fpc, "rand");
    end
`ifdef BRANCH_STATS_EN
    #1;
    check("rand.branch_count", branch_count, STAT_WIDTH'(sat_stat(stat_br)));
    check("rand.mispredict_count", mispredict_count, STAT_WIDTH'(sat_stat(stat_mp)));
`endif

    // Asynchronous reset mid-cycle; resolution stays combinational
    check_fetch(32'h40, "midreset.before");
    #2;
    reset_n = 1'b0;
    #1;
    check("midreset.predict", predict_taken, 1'b0);
`ifdef BRANCH_STATS_EN
    check("midreset.branch_count", branch_count, '0);
    check("midreset.mispredict_count", mispredict_count, '0);
`endif
    branch_en    = 1'b1;
    cond         = 3'd0;
    alu_zero     = 1'b1;
    resolve_pc   = 32'h40;
    resolve_pred = 1'b0;
    #1;
    check("midreset.branch", branch, 1'b1);
    check("midreset.mispredict", mispredict, 1'b1);
    @(posedge clk);
    #1;
    check("midreset.no_update", predict_taken, 1'b0);
    @(negedge clk);
    branch_en = 1'b0;
    reset_n   = 1'b1;
    model_reset();
    check_fetch(32'h40, "postreset.predict");

    // First edge with reset released trains the table
    do_cycle(1'b1, 0, 1'b1, 1'b0, 32'h40, 1'b0, 32'h40, "postreset.train");
    check_fetch(32'h40, "postreset.trained");

`ifdef BRANCH_STATS_EN
    // 20 valid branches, 5 mispredicted, on fresh counters
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    model_reset();
    for (int k = 0; k < 20; k++) begin
      do_cycle(1'b1, 0, 1'b1, 1'b0, 32'h60, (k % 4) != 0, 32'h60, "stats");
      if (k == 9) begin
        #1;
        check("stats.branch_count.10", branch_count, STAT_WIDTH'(sat_stat(stat_br)));
      end
    end
    #1;
    check("stats.branch_count", branch_count, STAT_WIDTH'(15));
    check("stats.mispredict_count", mispredict_count, STAT_WIDTH'(5));
    check("stats.model_br", branch_count, STAT_WIDTH'(sat_stat(stat_br)));
    #2;
    reset_n = 1'b0;
    #1;
    check("stats.reset.branch_count", branch_count, '0);
    check("stats.reset.mispredict_count", mispredict_count, '0);
    @(negedge clk);
    reset_n = 1'b1;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
